rtype_exec_unit: RTL and testbench

// Multi-cycle execute/write-back stage for MIPS R-type instructions.
// - Sits between instruction fetch/decode and the 32x32 register file (register).
// - Accepts one 32-bit instruction per handshake.
// - Drives the register file read ports and latches both operands.
// - Computes the ALU result and writes it back through the register file write port.
// - Only one instruction is in flight; completion is flagged with done/err/ovf.
//

---
 rtl/exec_pkg.sv | 40 ++++
 rtl/alu32.sv | 50 +++++
 rtl/rtype_exec_unit.sv | 106 ++++++++++
 tb/tb_rtype_exec_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types and constants for the R-type execute/write-back stage.
package exec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;

    // Instruction field boundaries
    localparam int unsigned OP_HI    = 31;
    localparam int unsigned OP_LO    = 26;
    localparam int unsigned RS_HI    = 25;
    localparam int unsigned RS_LO    = 21;
    localparam int unsigned RT_HI    = 20;
    localparam int unsigned RT_LO    = 16;
    localparam int unsigned RD_HI    = 15;
    localparam int unsigned RD_LO    = 11;
    localparam int unsigned SHAMT_HI = 10;
    localparam int unsigned SHAMT_LO = 6;
    localparam int unsigned FUNCT_HI = 5;
    localparam int unsigned FUNCT_LO = 0;

endpackage

// File: rtl/alu32.sv
// Combinational R-type ALU: result, signed overflow for add/sub, illegal funct flag.
module alu32
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    output logic [DATA_W-1:0] result,
    output logic              ovf,
    output logic              illegal
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    // Operation select and overflow detection
    always_comb begin
        result  = '0;
        ovf     = 1'b0;
        illegal = 1'b0;
        case (funct)
            F_ADD: begin
                result = sum;
                ovf    = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            F_ADDU: result = sum;
            F_SUB: begin
                result = diff;
                ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            F_SUBU: result = diff;
            F_AND:  result = a & b;
            F_OR:   result = a | b;
            F_XOR:  result = a ^ b;
            F_NOR:  result = ~(a | b);
            F_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            F_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
            F_SLL:  result = b << shamt;
            F_SRL:  result = b >> shamt;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rtype_exec_unit.sv
// Multi-cycle R-type execute/write-back stage: IDLE -> READ -> EXEC -> WB.
module rtype_exec_unit
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              inst_valid,
    input  logic [31:0]       inst,
    output logic              inst_ready,
    output logic [ADDR_W-1:0] R_Addr_A,
    output logic [ADDR_W-1:0] R_Addr_B,
    input  logic [DATA_W-1:0] R_Data_A,
    input  logic [DATA_W-1:0] R_Data_B,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic              Write_Reg,
    output logic              done,
    output logic              err,
    output logic              ovf
);

    state_e            state_q, state_d;
    logic [31:0]       inst_q;
    logic [DATA_W-1:0] a_q, b_q, result_q;
    logic [ADDR_W-1:0] waddr_q;
    logic              err_q, ovf_q;
    logic              accept;

    logic [DATA_W-1:0] alu_result;
    logic              alu_ovf, alu_illegal, illegal_op;

    alu32 #(.DATA_W(DATA_W)) u_alu (
        .a       (a_q),
        .b       (b_q),
        .shamt   (inst_q[SHAMT_HI:SHAMT_LO]),
        .funct   (inst_q[FUNCT_HI:FUNCT_LO]),
        .result  (alu_result),
        .ovf     (alu_ovf),
        .illegal (alu_illegal)
    );

    assign illegal_op = alu_illegal || (inst_q[OP_HI:OP_LO] != OP_RTYPE);
    assign accept     = inst_valid && inst_ready;

    // Read addresses come straight from the captured instruction, so they hold until the next accept
    assign R_Addr_A = inst_q[RS_HI:RS_LO];
    assign R_Addr_B = inst_q[RT_HI:RT_LO];
    assign W_Addr   = waddr_q;
    assign W_Data   = result_q;
    assign err      = err_q;
    assign ovf      = ovf_q;

    // State register
    always_ff @(posedge clk) begin
        if (!Reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = READ;
            READ:    state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and retire outputs; all gated by reset so an abort never writes
    always_comb begin
        inst_ready = Reset && (state_q == IDLE);
        done       = Reset && (state_q == WB);
        Write_Reg  = done && !err_q && !ovf_q && (waddr_q != '0);
    end

    // Instruction capture, operand latch and result latch
    always_ff @(posedge clk) begin
        if (!Reset) begin
            inst_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            waddr_q  <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (accept) inst_q <= inst;
            if (state_q == READ) begin
                a_q <= R_Data_A;
                b_q <= R_Data_B;
            end
            if (state_q == EXEC) begin
                result_q <= alu_result;
                waddr_q  <= inst_q[RD_HI:RD_LO];
                err_q    <= illegal_op;
                ovf_q    <= alu_ovf && !illegal_op;
            end
        end
    end

endmodule

// File: tb/tb_rtype_exec_unit.sv
// Bench for rtype_exec_unit with a behavioural 32x32 register file and preload mux.
module tb_rtype_exec_unit;

    logic        clk = 1'b0;
    logic        Reset;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_ready;
    logic [4:0]  R_Addr_A, R_Addr_B, W_Addr;
    logic [31:0] R_Data_A, R_Data_B, W_Data;
    logic        Write_Reg, done, err, ovf;

    logic [31:0] rf [32];
    logic        pl_en, rf_clr;
    logic [4:0]  pl_addr;
    logic [31:0] pl_data;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    rtype_exec_unit #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_ready (inst_ready),
        .R_Addr_A   (R_Addr_A),
        .R_Addr_B   (R_Addr_B),
        .R_Data_A   (R_Data_A),
        .R_Data_B   (R_Data_B),
        .W_Addr     (W_Addr),
        .W_Data     (W_Data),
        .Write_Reg  (Write_Reg),
        .done       (done),
        .err        (err),
        .ovf        (ovf)
    );

    // Register file: combinational read, r0 hardwired to zero, preload has priority on the write port
    assign R_Data_A = (R_Addr_A == 5'd0) ? 32'd0 : rf[R_Addr_A];
    assign R_Data_B = (R_Addr_B == 5'd0) ? 32'd0 : rf[R_Addr_B];
    assign rf_we    = pl_en | Write_Reg;
    assign rf_wa    = pl_en ? pl_addr : W_Addr;
    assign rf_wd    = pl_en ? pl_data : W_Data;

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (rf_we && rf_wa != 5'd0) begin
            rf[rf_wa] <= rf_wd;
        end
    end

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        chk_wd;
        logic        we;
        logic        er;
        logic        ov;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
        return {op, rs, rt, rd, sh, fn};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Waits (bounded) for ready, issues one instruction and returns at the negedge inside WB (T3)
    task automatic issue(input logic [31:0] ins);
        int unsigned k = 0;
        @(negedge clk);
        while (!inst_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!inst_ready) chk("ready_timeout", {31'd0, inst_ready}, 32'd1);
        inst_valid = 1'b1; inst = ins;
        @(negedge clk);
        inst_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old;
        Reset = 1'b0; inst_valid = 1'b0; inst = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0; rf_clr = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, inst_ready}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_wreg",  {31'd0, Write_Reg}, 32'd0);
        chk("rst_waddr", {27'd0, W_Addr}, 32'd0);
        chk("rst_wdata", W_Data, 32'd0);
        Reset = 1'b1; rf_clr = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", {31'd0, inst_ready}, 32'd1);

        preload(5'd1, 32'd3);
        preload(5'd2, 32'd4);
        preload(5'd4, 32'h8000_0000);
        preload(5'd5, 32'd1);
        preload(5'd7, 32'hFFFF_FFFF);

        // Reset while in EXEC aborts without a write
        @(negedge clk);
        inst_valid = 1'b1; inst = enc(6'h00, 5'd1, 5'd2, 5'd16, 5'd0, 6'h20);
        @(negedge clk);
        inst_valid = 1'b0;
        @(negedge clk);
        Reset = 1'b0;
        chk("abort_wreg_exec", {31'd0, Write_Reg}, 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("abort_wreg", {31'd0, Write_Reg}, 32'd0);
            chk("abort_done", {31'd0, done}, 32'd0);
            chk("abort_ready_gated", {31'd0, inst_ready}, 32'd0);
        end
        Reset = 1'b1;
        @(negedge clk);
        chk("abort_ready", {31'd0, inst_ready}, 32'd1);
        chk("abort_done_after", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_write_r16", rf[16], 32'd0);

        // name, instruction, W_Addr, W_Data, check W_Data, Write_Reg, err, ovf
        vecs.push_back('{"add_r3",      32'h0022_1820,                            5'd3,  32'd7,          1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"sub_ovf",     enc(6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'h22), 5'd6,  32'd0,          1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"subu",        enc(6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'h23), 5'd6,  32'h7FFF_FFFF,  1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"slt",         enc(6'h00, 5'd7, 5'd1, 5'd9, 5'd0, 6'h2A), 5'd9,  32'd1,          1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"sltu",        enc(6'h00, 5'd7, 5'd1, 5'd9, 5'd0, 6'h2B), 5'd9,  32'd0,          1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"srl4",        enc(6'h00, 5'd0, 5'd7, 5'd9, 5'd4, 6'h02), 5'd9,  32'h0FFF_FFFF,  1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"add_rd0",     enc(6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20), 5'd0,  32'd7,          1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"funct3f",     enc(6'h00, 5'd1, 5'd2, 5'd10, 5'd0, 6'h3F), 5'd10, 32'd0,         1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"op08",        enc(6'h08, 5'd1, 5'd2, 5'd10, 5'd0, 6'h20), 5'd10, 32'd0,         1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"addu_wrap",   enc(6'h00, 5'd4, 5'd4, 5'd10, 5'd0, 6'h21), 5'd10, 32'd0,         1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"add_ovf",     enc(6'h00, 5'd4, 5'd4, 5'd17, 5'd0, 6'h20), 5'd17, 32'd0,         1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"add_neg",     enc(6'h00, 5'd7, 5'd1, 5'd11, 5'd0, 6'h20), 5'd11, 32'd2,         1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"and",         enc(6'h00, 5'd7, 5'd2, 5'd11, 5'd0, 6'h24), 5'd11, 32'd4,         1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"or",          enc(6'h00, 5'd1, 5'd2, 5'd12, 5'd0, 6'h25), 5'd12, 32'd7,         1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"xor",         enc(6'h00, 5'd1, 5'd7, 5'd12, 5'd0, 6'h26), 5'd12, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"nor",         enc(6'h00, 5'd1, 5'd2, 5'd13, 5'd0, 6'h27), 5'd13, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"sll3",        enc(6'h00, 5'd0, 5'd1, 5'd14, 5'd3, 6'h00), 5'd14, 32'd24,        1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"sub_neg",     enc(6'h00, 5'd1, 5'd2, 5'd15, 5'd0, 6'h22), 5'd15, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0});

        foreach (vecs[i]) begin
            old = rf[vecs[i].wa];
            issue(vecs[i].ins);
            chk({vecs[i].name, "_done"},  {31'd0, done},      32'd1);
            chk({vecs[i].name, "_wreg"},  {31'd0, Write_Reg}, {31'd0, vecs[i].we});
            chk({vecs[i].name, "_err"},   {31'd0, err},       {31'd0, vecs[i].er});
            chk({vecs[i].name, "_ovf"},   {31'd0, ovf},       {31'd0, vecs[i].ov});
            chk({vecs[i].name, "_waddr"}, {27'd0, W_Addr},    {27'd0, vecs[i].wa});
            if (vecs[i].chk_wd) chk({vecs[i].name, "_wdata"}, W_Data, vecs[i].wd);
            @(negedge clk);
            chk({vecs[i].name, "_ready_t4"}, {31'd0, inst_ready}, 32'd1);
            chk({vecs[i].name, "_done_t4"},  {31'd0, done}, 32'd0);
            if (vecs[i].wa != 5'd0)
                chk({vecs[i].name, "_rf"}, rf[vecs[i].wa], vecs[i].we ? vecs[i].wd : old);
        end

        // Back-to-back with inst_valid held high: second instruction reads committed r3
        preload(5'd3, 32'd0);
        @(negedge clk);
        inst_valid = 1'b1; inst = 32'h0022_1820;
        @(negedge clk);
        inst = 32'h0063_4020;
        chk("b2b_ready_t1", {31'd0, inst_ready}, 32'd0);
        @(negedge clk);
        chk("b2b_ready_t2", {31'd0, inst_ready}, 32'd0);
        @(negedge clk);
        chk("b2b_done1", {31'd0, done}, 32'd1);
        chk("b2b_ready_t3", {31'd0, inst_ready}, 32'd0);
        chk("b2b_waddr1", {27'd0, W_Addr}, 32'd3);
        chk("b2b_wdata1", W_Data, 32'd7);
        @(negedge clk);
        chk("b2b_ready_t4", {31'd0, inst_ready}, 32'd1);
        @(negedge clk);
        inst_valid = 1'b0;
        chk("b2b_ready_t5", {31'd0, inst_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_done2", {31'd0, done}, 32'd1);
        chk("b2b_wreg2", {31'd0, Write_Reg}, 32'd1);
        chk("b2b_waddr2", {27'd0, W_Addr}, 32'd8);
        chk("b2b_wdata2", W_Data, 32'd14);
        @(negedge clk);
        chk("b2b_r8", rf[8], 32'd14);
        @(negedge clk);
        chk("b2b_no_extra", {31'd0, inst_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
